// File: rtl/fifo_sync_pkg.sv
// Shared types and sizing helpers for the FIFO read-side arbitration logic.
package fifo_sync_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQUESTERS = 4;
    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_MAX_BURST      = 4;

    // Beat counter must hold 0..max_burst inclusive.
    function automatic int unsigned beat_cnt_width(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester strictly after the last owner, wrapping N-1 -> 0.
module rr_priority_picker #(
    parameter  int unsigned NUM_REQUESTERS = 4,
    localparam int unsigned IDX_W          = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic [IDX_W-1:0]          last,
    output logic [NUM_REQUESTERS-1:0] pick,
    output logic                      valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQUESTERS; i++) begin
            idx = IDX_W'((32'(last) + i) % NUM_REQUESTERS);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares the FIFO read port among consumers in round-robin bursts, with a
// one-entry registered output stage using a valid/ready handshake.
module fifo_read_arbiter
    import fifo_sync_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = DEF_NUM_REQUESTERS,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned MAX_BURST      = DEF_MAX_BURST
) (
    input  logic                      read_clk,
    input  logic                      read_reset,
    input  logic                      fifo_empty,
    input  logic [DATA_WIDTH-1:0]     fifo_read_data,
    output logic                      read_enable,
    input  logic [NUM_REQUESTERS-1:0] consumer_req,
    input  logic [NUM_REQUESTERS-1:0] consumer_ready,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data
);

    localparam int unsigned       IDX_W    = $clog2(NUM_REQUESTERS);
    localparam int unsigned       BEAT_W   = beat_cnt_width(MAX_BURST);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

    arb_state_t                state;
    logic [IDX_W-1:0]          rr_ptr;
    logic [IDX_W-1:0]          owner;
    logic [BEAT_W-1:0]         beats;
    logic [NUM_REQUESTERS-1:0] pick;
    logic                      pick_valid;
    logic [IDX_W-1:0]          pick_idx;
    logic                      take;
    logic                      stage_free;
    logic                      end_burst;

    rr_priority_picker #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_picker (
        .req  (consumer_req),
        .last (rr_ptr),
        .pick (pick),
        .valid(pick_valid)
    );

    // Binary index of the one-hot pick, remembered as the burst owner.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    assign take       = out_valid && |(grant & consumer_ready);
    assign stage_free = !out_valid || take;

    assign read_enable = (state == ARB_BURST) && !fifo_empty && (beats < BEAT_MAX)
                         && consumer_req[owner] && stage_free;

    // A pending word always reaches its owner before the burst may close.
    assign end_burst = (state == ARB_BURST) && stage_free && !read_enable
                       && ((beats == BEAT_MAX) || !consumer_req[owner] || fifo_empty);

    always_ff @(posedge read_clk or posedge read_reset) begin
        if (read_reset) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            beats     <= '0;
            owner     <= '0;
            rr_ptr    <= IDX_W'(NUM_REQUESTERS - 1);
        end else begin
            if (read_enable) begin
                out_data  <= fifo_read_data;
                out_valid <= 1'b1;
                beats     <= beats + 1'b1;
            end else if (take) begin
                out_valid <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (pick_valid && !fifo_empty) begin
                        state <= ARB_BURST;
                        grant <= pick;
                        owner <= pick_idx;
                        beats <= '0;
                    end
                end
                ARB_BURST: begin
                    if (end_burst) begin
                        state  <= ARB_IDLE;
                        grant  <= '0;
                        rr_ptr <= owner;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Scoreboarded bench for fifo_read_arbiter with a show-ahead FIFO model.
module tb_fifo_read_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            owner;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_read_data = '0;
    logic          re;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  ready = '0;
    logic [N-1:0]  grant;
    logic          out_valid;
    logic [DW-1:0] out_data;

    logic [DW-1:0] fifo_q[$];
    exp_t          exp_q[$];
    logic          do_pop = 1'b0;
    int            n_checks = 0;
    int            n_fails = 0;
    int            pops_total = 0;
    int            re_empty_viol = 0;
    int            blen[$];
    int            gaps[$];
    int            gseq[$];

    always #5 clk = ~clk;

    fifo_read_arbiter #(
        .NUM_REQUESTERS(N),
        .DATA_WIDTH    (DW),
        .MAX_BURST     (4)
    ) dut (
        .read_clk      (clk),
        .read_reset    (rst),
        .fifo_empty    (fifo_empty),
        .fifo_read_data(fifo_read_data),
        .read_enable   (re),
        .consumer_req  (req),
        .consumer_ready(ready),
        .grant         (grant),
        .out_valid     (out_valid),
        .out_data      (out_data)
    );

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input int owner, input bit expect_out);
        exp_t e;
        fifo_q.push_back(d);
        if (expect_out) begin
            e.data  = d;
            e.owner = owner;
            exp_q.push_back(e);
        end
    endtask

    // Show-ahead FIFO: pops at the edge where read_enable was high.
    task automatic fifo_model();
        forever begin
            @(posedge clk);
            #2;
            if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            do_pop         = 1'b0;
            fifo_empty     = (fifo_q.size() == 0);
            fifo_read_data = fifo_empty ? '0 : fifo_q[0];
        end
    endtask

    // Compares every handshake against the next expected word and owner.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            do_pop = 1'b0;
            if (!rst) begin
                if (re) begin
                    pops_total++;
                    do_pop = 1'b1;
                    if (fifo_empty) re_empty_viol++;
                end
                if (out_valid && |(grant & ready)) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL sb_unexpected: got word %0d with no expected entry", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", int'(out_data), int'(e.data));
                        check("sb_owner", onehot_idx(grant), e.owner);
                    end
                end
            end
        end
    endtask

    task automatic run_bursts(input int cycles);
        int cur = 0;
        int gap = 0;
        bit seen = 0;
        bit prev = 0;
        blen.delete();
        gaps.delete();
        gseq.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (|grant) begin
                if (!prev) begin
                    if (seen) gaps.push_back(gap);
                    gseq.push_back(int'(grant));
                end
                if (re) cur++;
                seen = 1;
            end else begin
                if (prev) begin
                    blen.push_back(cur);
                    cur = 0;
                    gap = 0;
                end
                if (seen) gap++;
            end
            prev = |grant;
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !out_valid && (grant == '0);
        end
        check(name, int'(ok), 1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            ok = out_valid;
        end
        check(name, int'(ok), 1);
    endtask

    task automatic wait_grant(input string name, input bit want_any);
        bit ok = 0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            ok = want_any ? (grant != '0) : (grant == '0);
        end
        check(name, int'(ok), 1);
    endtask

    initial begin
        int p0;
        fork
            monitor();
            fifo_model();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_re", int'(re), 0);

        // All four requesting, FIFO kept full: 0,1,2,3,0 in bursts of 4
        step();
        for (int i = 0; i < 20; i++) push_word(DW'(8'h10 + i), (i / 4) % 4, 1);
        req = 4'b1111;
        ready = 4'b1111;
        run_bursts(80);
        check("rr_nbursts", gseq.size(), 5);
        check("rr_g0", gseq.size() > 0 ? gseq[0] : -1, 1);
        check("rr_g1", gseq.size() > 1 ? gseq[1] : -1, 2);
        check("rr_g2", gseq.size() > 2 ? gseq[2] : -1, 4);
        check("rr_g3", gseq.size() > 3 ? gseq[3] : -1, 8);
        check("rr_g4", gseq.size() > 4 ? gseq[4] : -1, 1);
        for (int i = 0; i < 5; i++) check("rr_len", blen.size() > i ? blen[i] : -1, 4);
        step();
        req = '0;
        wait_drain("rr_drain");

        // Single consumer, 10 words: bursts 4,4,2 with one idle cycle between
        step();
        p0 = pops_total;
        for (int i = 0; i < 10; i++) push_word(DW'(8'h40 + i), 1, 1);
        req = 4'b0010;
        ready = 4'b0010;
        run_bursts(60);
        check("single_nbursts", blen.size(), 3);
        check("single_len0", blen.size() > 0 ? blen[0] : -1, 4);
        check("single_len1", blen.size() > 1 ? blen[1] : -1, 4);
        check("single_len2", blen.size() > 2 ? blen[2] : -1, 2);
        check("single_gap0", gaps.size() > 0 ? gaps[0] : -1, 1);
        check("single_gap1", gaps.size() > 1 ? gaps[1] : -1, 1);
        check("single_pops", pops_total - p0, 10);
        step();
        req = '0;
        wait_drain("single_drain");

        // Owner stalls with a word pending: no pop, data and grant stable
        step();
        push_word(8'hA0, 2, 1);
        push_word(8'hA1, 2, 1);
        push_word(8'hA2, 2, 1);
        req = 4'b0100;
        ready = 4'b0000;
        wait_valid("stall_valid");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_re", int'(re), 0);
            check("stall_data", int'(out_data), 8'hA0);
            check("stall_grant", int'(grant), 4'b0100);
        end
        step();
        ready = 4'b0100;
        wait_drain("stall_drain");
        step();
        req = '0;

        // FIFO runs dry after two words; next requester gets the refill
        step();
        push_word(8'hB0, 0, 1);
        push_word(8'hB1, 0, 1);
        req = 4'b0011;
        ready = 4'b0011;
        wait_grant("empty_grant_up", 1);
        check("empty_owner0", int'(grant), 4'b0001);
        wait_grant("empty_grant_down", 0);
        check("empty_all_taken", exp_q.size(), 0);
        check("empty_flag", int'(fifo_empty), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_idle_grant", int'(grant), 0);
            check("empty_idle_re", int'(re), 0);
        end
        step();
        push_word(8'hC0, 1, 1);
        push_word(8'hC1, 1, 1);
        wait_grant("refill_grant_up", 1);
        check("refill_owner1", int'(grant), 4'b0010);
        wait_drain("refill_drain");
        step();
        req = '0;

        // Owner drops request with a word pending: delivered, no further pop
        step();
        p0 = pops_total;
        push_word(8'hD0, 3, 1);
        push_word(8'hD1, 0, 0);
        push_word(8'hD2, 0, 0);
        req = 4'b1000;
        ready = 4'b0000;
        wait_valid("drop_valid");
        step();
        req = '0;
        @(negedge clk);
        check("drop_re", int'(re), 0);
        check("drop_grant_held", int'(grant), 4'b1000);
        check("drop_valid_held", int'(out_valid), 1);
        step();
        ready = 4'b1000;
        wait_grant("drop_grant_down", 0);
        check("drop_pops", pops_total - p0, 1);
        check("drop_fifo_left", fifo_q.size(), 2);
        check("drop_delivered", exp_q.size(), 0);
        step();
        push_word(8'hD1, 0, 1);
        void'(fifo_q.pop_back());
        push_word(8'hD2, 0, 1);
        void'(fifo_q.pop_back());
        req = 4'b0001;
        ready = 4'b0001;
        wait_drain("drop_rest_drain");
        step();
        req = '0;

        // Reset mid-burst with a word held, then a fresh single request
        step();
        push_word(8'hE0, 1, 0);
        push_word(8'hE1, 1, 0);
        req = 4'b0010;
        ready = 4'b0000;
        wait_valid("mid_rst_valid");
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_grant", int'(grant), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_re", int'(re), 0);
        @(negedge clk);
        fifo_q.delete();
        exp_q.delete();
        push_word(8'hF0, 2, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        req = 4'b0100;
        ready = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_grant", int'(grant), 4'b0100);
        wait_drain("post_rst_drain");
        step();
        req = '0;

        repeat (3) @(negedge clk);
        check("no_pop_when_empty", re_empty_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
